// File: rtl/gate_operand_fetch_pkg.sv
// gate_operand_fetch_pkg
// Shared types for the operand-fetch stage and the gate-scheduler stage:
//   - fetch_state_e : operand-fetch FSM states (IDLE, HOLD)
//   - gate_desc_t   : gate descriptor {addr_a, addr_b, single, out_addr, tag}
//   - sat_inc16     : saturating 16-bit increment used by the stall counter
package gate_operand_fetch_pkg;

    localparam int unsigned GOF_S = 13;   // wire-address width of the label RAM
    localparam int unsigned GOF_T = 8;    // opaque tag width

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [GOF_S-1:0] addr_a;
        logic [GOF_S-1:0] addr_b;
        logic             single;
        logic [GOF_S-1:0] out_addr;
        logic [GOF_T-1:0] tag;
    } gate_desc_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gate_operand_fetch_op_fifo.sv
// op_fifo
// Synchronous FIFO holding fetched operand bundles for the evaluation core.
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   push_i/push_data_i : write one entry (caller guarantees space)
//   pop_i              : remove head when valid_o
//   pop_data_o         : head entry, forced to zero while empty
//   valid_o            : FIFO not empty
//   count_o            : number of stored entries (0..D)
module op_fifo #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           pop_data_o,
    output logic                   valid_o,
    output logic [$clog2(D):0]     count_o
);

    localparam int unsigned AW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign valid_o    = (count_q != '0);
    assign do_pop     = pop_i & valid_o;
    assign do_push    = push_i & ((count_q != (AW+1)'(D)) | do_pop);
    assign count_o    = count_q;
    // Zero the head while empty so the outputs read 0 out of reset.
    assign pop_data_o = valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_operand_fetch.sv
// gate_operand_fetch
// Operand-fetch stage: holds one gate descriptor, waits for both input labels
// to be written in the label DPRAM, issues a paired read, captures the labels
// one cycle later and queues them with the descriptor metadata.
// Ports:
//   clk, rst (async, active-high), clr (sync flush)
//   in_*        : descriptor input (valid/ready)
//   rd_*        : label RAM read ports 0/1, flags, stall and t+1 data
//   out_*       : operand bundle output (valid/ready)
//   wait_cycles : saturating count of HOLD cycles without an issue
module gate_operand_fetch
    import gate_operand_fetch_pkg::*;
#(
    parameter int unsigned S = 13,
    parameter int unsigned K = 128,
    parameter int unsigned T = 8,
    parameter int unsigned D = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [S-1:0]  in_addr_a,
    input  logic [S-1:0]  in_addr_b,
    input  logic          in_single,
    input  logic [S-1:0]  in_out_addr,
    input  logic [T-1:0]  in_tag,
    output logic          rd_req_0,
    output logic          rd_req_1,
    output logic [S-1:0]  rd_addr_0,
    output logic [S-1:0]  rd_addr_1,
    input  logic          rd_data_ready_0,
    input  logic          rd_data_ready_1,
    input  logic          stall_rd,
    input  logic [K-1:0]  rd_data_0_t1,
    input  logic [K-1:0]  rd_data_1_t1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_label_a,
    output logic [K-1:0]  out_label_b,
    output logic [S-1:0]  out_addr,
    output logic [T-1:0]  out_tag,
    output logic [15:0]   wait_cycles
);

    localparam int unsigned CW = $clog2(D) + 1;
    localparam int unsigned FW = 2 * K + S + T;

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    gate_desc_t     hold_q;
    logic           pend_q;
    logic           pend_single_q;
    logic [S-1:0]   pend_addr_q;
    logic [T-1:0]   pend_tag_q;
    logic [15:0]    wait_q;

    logic           in_hold;
    logic           accept;
    logic           can_issue;
    logic           issue;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    credit_used;
    logic [K-1:0]   label_b_t1;
    logic [FW-1:0]  push_data;
    logic [FW-1:0]  head_data;
    logic           fifo_valid;

    assign in_hold     = (state_q == HOLD);
    // The read in flight (pend) already owns a FIFO slot; a same-cycle pop
    // is deliberately not credited back.
    assign credit_used = {1'b0, fifo_count} + (CW+1)'(pend_q);
    assign can_issue   = in_hold & rd_data_ready_0 & (hold_q.single | rd_data_ready_1)
                       & (credit_used < (CW+1)'(D));
    assign issue       = can_issue & ~stall_rd;

    assign rd_req_0    = can_issue;
    assign rd_req_1    = can_issue & ~hold_q.single;
    assign rd_addr_0   = in_hold ? hold_q.addr_a : '0;
    assign rd_addr_1   = in_hold ? hold_q.addr_b : '0;

    assign in_ready    = ~in_hold | issue;
    assign accept      = in_valid & in_ready;
    assign wait_cycles = wait_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (issue && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            pend_q        <= 1'b0;
            pend_single_q <= 1'b0;
            pend_addr_q   <= '0;
            pend_tag_q    <= '0;
            wait_q        <= '0;
        end else if (clr) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            pend_q        <= 1'b0;
            pend_single_q <= 1'b0;
            pend_addr_q   <= '0;
            pend_tag_q    <= '0;
            wait_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hold_q <= '{addr_a:   in_addr_a,
                            addr_b:   in_addr_b,
                            single:   in_single,
                            out_addr: in_out_addr,
                            tag:      in_tag};
            end
            pend_q <= issue;
            if (issue) begin
                pend_single_q <= hold_q.single;
                pend_addr_q   <= hold_q.out_addr;
                pend_tag_q    <= hold_q.tag;
            end
            if (in_hold && !issue) begin
                wait_q <= sat_inc16(wait_q);
            end
        end
    end

    assign label_b_t1 = pend_single_q ? '0 : rd_data_1_t1;
    assign push_data  = {rd_data_0_t1, label_b_t1, pend_addr_q, pend_tag_q};

    op_fifo #(
        .W (FW),
        .D (D)
    ) u_op_fifo (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .push_i      (pend_q),
        .push_data_i (push_data),
        .pop_i       (out_ready),
        .pop_data_o  (head_data),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign {out_label_a, out_label_b, out_addr, out_tag} = head_data;

endmodule

// File: tb/tb_gate_operand_fetch.sv
module tb_gate_operand_fetch;

    localparam int unsigned S = 13;
    localparam int unsigned K = 128;
    localparam int unsigned T = 8;
    localparam int unsigned D = 4;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [S-1:0]  in_addr_a;
    logic [S-1:0]  in_addr_b;
    logic          in_single;
    logic [S-1:0]  in_out_addr;
    logic [T-1:0]  in_tag;
    logic          rd_req_0;
    logic          rd_req_1;
    logic [S-1:0]  rd_addr_0;
    logic [S-1:0]  rd_addr_1;
    logic          rd_data_ready_0;
    logic          rd_data_ready_1;
    logic          stall_rd;
    logic [K-1:0]  rd_data_0_t1;
    logic [K-1:0]  rd_data_1_t1;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_label_a;
    logic [K-1:0]  out_label_b;
    logic [S-1:0]  out_addr;
    logic [T-1:0]  out_tag;
    logic [15:0]   wait_cycles;

    gate_operand_fetch #(.S(S), .K(K), .T(T), .D(D)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .in_single(in_single),
        .in_out_addr(in_out_addr), .in_tag(in_tag),
        .rd_req_0(rd_req_0), .rd_req_1(rd_req_1),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_data_ready_0(rd_data_ready_0), .rd_data_ready_1(rd_data_ready_1),
        .stall_rd(stall_rd),
        .rd_data_0_t1(rd_data_0_t1), .rd_data_1_t1(rd_data_1_t1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_label_a(out_label_a), .out_label_b(out_label_b),
        .out_addr(out_addr), .out_tag(out_tag),
        .wait_cycles(wait_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- label RAM model ----------------
    function automatic logic [K-1:0] lab(input logic [S-1:0] a);
        logic [31:0] x;
        x = {19'h0, a};
        return {x * 32'h9E3779B1 ^ 32'hA5A50000, x * 32'h85EBCA6B + 32'd7, ~x, x ^ 32'hC0DE0001};
    endfunction

    logic flag [8192];
    logic blk0, blk1;
    assign rd_data_ready_0 = flag[rd_addr_0] & ~blk0;
    assign rd_data_ready_1 = flag[rd_addr_1] & ~blk1;

    // Rejected or absent reads return garbage.
    always @(posedge clk) begin
        rd_data_0_t1 <= (rd_req_0 && !stall_rd) ? lab(rd_addr_0) : {4{$urandom}};
        rd_data_1_t1 <= (rd_req_1 && !stall_rd) ? lab(rd_addr_1) : {4{$urandom}};
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [K-1:0] la;
        logic [K-1:0] lb;
        logic [S-1:0] oa;
        logic [T-1:0] tg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pop = 0;
    int   n_issue = 0;

    task automatic chk(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic          prev_hold = 1'b0;
    logic          prev_clr = 1'b0;
    logic [K-1:0]  pla, plb;
    logic [S-1:0]  pad;
    logic [T-1:0]  ptg;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_clr  = 1'b0;
        end else begin
            exp_t e;
            if (rd_req_0 && !stall_rd) n_issue++;
            if (prev_hold && !prev_clr) begin
                chk("stable_valid", K'(out_valid), K'(1));
                chk("stable_label_a", out_label_a, pla);
                chk("stable_label_b", out_label_b, plb);
                chk("stable_meta", K'({out_addr, out_tag}), K'({pad, ptg}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got addr %0h tag %0h, expected no output", out_addr, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("out_label_a", out_label_a, e.la);
                    chk("out_label_b", out_label_b, e.lb);
                    chk("out_addr", K'(out_addr), K'(e.oa));
                    chk("out_tag", K'(out_tag), K'(e.tg));
                    n_pop++;
                end
            end
            prev_hold = out_valid & ~out_ready;
            prev_clr  = clr;
            pla = out_label_a; plb = out_label_b; pad = out_addr; ptg = out_tag;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [S-1:0] a, input logic [S-1:0] b, input logic sg,
                        input logic [S-1:0] oa, input logic [T-1:0] tg);
        int unsigned n;
        bit ok;
        exp_t e;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1; in_addr_a = a; in_addr_b = b; in_single = sg;
        in_out_addr = oa; in_tag = tg;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                e.la = lab(a);
                e.lb = sg ? '0 : lab(b);
                e.oa = oa;
                e.tg = tg;
                sb.push_back(e);
            end
            n++;
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept within 300 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_accept();
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_valid && in_ready) && n < 50);
        if (!(in_valid && in_ready)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", K'(sb.size()), K'(0));
        repeat (3) @(negedge clk);
        chk("drain_out_valid", K'(out_valid), K'(0));
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0, i0;
        bit rand_on;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_addr_a = '0; in_addr_b = '0;
        in_single = 1'b0; in_out_addr = '0; in_tag = '0; stall_rd = 1'b0;
        out_ready = 1'b1; blk0 = 1'b0; blk1 = 1'b0;
        for (int i = 0; i < 8192; i++) flag[i] = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", K'(in_ready), K'(1));
        chk("rst_rd_req", K'({rd_req_0, rd_req_1}), K'(0));
        chk("rst_rd_addr", K'({rd_addr_0, rd_addr_1}), K'(0));
        chk("rst_out_valid", K'(out_valid), K'(0));
        chk("rst_out_fields", out_label_a | out_label_b | K'({out_addr, out_tag}), K'(0));
        chk("rst_wait", K'(wait_cycles), K'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // back-to-back descriptors, 2-cycle latency
        fork
            begin
                send(13'd5, 13'd9, 1'b0, 13'd100, 8'h11);
                send(13'd3, 13'd3, 1'b0, 13'd101, 8'h22);
            end
            begin
                wait_accept();
                @(negedge clk);
                chk("b2b_req_first", K'({rd_req_0, rd_req_1}), K'(2'b11));
                chk("b2b_addr_first", K'({rd_addr_0, rd_addr_1}), K'({13'd5, 13'd9}));
                @(negedge clk);
                chk("b2b_req_second", K'({rd_req_0, rd_req_1}), K'(2'b11));
                chk("b2b_addr_second", K'({rd_addr_0, rd_addr_1}), K'({13'd3, 13'd3}));
                @(negedge clk);
                chk("b2b_latency_valid", K'(out_valid), K'(1));
                chk("b2b_latency_label", out_label_a, lab(13'd5));
                @(negedge clk);
                chk("b2b_second_valid", K'(out_valid), K'(1));
                chk("b2b_same_addr", out_label_b, lab(13'd3));
            end
        join
        drain();

        // missing flag for 6 cycles
        pulse_clr();
        flag[9] = 1'b0;
        fork
            send(13'd5, 13'd9, 1'b0, 13'd200, 8'h33);
            begin
                wait_accept();
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("flag_no_req", K'(rd_req_0 | rd_req_1), K'(0));
                    @(posedge clk); #1;
                end
                flag[9] = 1'b1;
                @(negedge clk);
                chk("flag_issue", K'({rd_req_0, rd_req_1}), K'(2'b11));
                chk("flag_wait_cycles", K'(wait_cycles), K'(6));
            end
        join
        drain();

        // two stalled issue cycles
        p0 = n_pop; i0 = n_issue;
        fork
            send(13'd12, 13'd20, 1'b0, 13'd300, 8'h44);
            begin
                wait_accept();
                @(posedge clk); #1;
                stall_rd = 1'b1;
                @(negedge clk);
                chk("stall_req_1", K'(rd_req_0), K'(1));
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_req_2", K'(rd_req_0), K'(1));
                @(posedge clk); #1;
                stall_rd = 1'b0;
                @(negedge clk);
                chk("stall_req_3", K'(rd_req_0), K'(1));
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_req_done", K'(rd_req_0), K'(0));
            end
        join
        drain();
        chk("stall_one_entry", K'(n_pop - p0), K'(1));
        chk("stall_one_issue", K'(n_issue - i0), K'(1));

        // FIFO full with consumer stalled
        out_ready = 1'b0;
        p0 = n_pop; i0 = n_issue;
        for (int i = 0; i < 5; i++) begin
            send(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)), 1'b0,
                 13'(400 + i), 8'(i));
        end
        in_valid = 1'b1; in_addr_a = 13'd77; in_addr_b = 13'd78; in_single = 1'b0;
        in_out_addr = 13'd405; in_tag = 8'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_in_ready", K'(in_ready), K'(0));
            chk("full_no_req", K'(rd_req_0), K'(0));
        end
        chk("full_issue_count", K'(n_issue - i0), K'(4));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(13'd77, 13'd78, 1'b0, 13'd405, 8'd5);
        drain();
        chk("full_drain_count", K'(n_pop - p0), K'(6));

        // single-operand gate; b's flag deliberately unset
        flag[300] = 1'b0;
        fork
            send(13'd7, 13'd300, 1'b1, 13'd500, 8'h55);
            begin
                wait_accept();
                @(negedge clk);
                chk("single_req_0", K'(rd_req_0), K'(1));
                chk("single_req_1", K'(rd_req_1), K'(0));
            end
        join
        drain();
        flag[300] = 1'b1;

        // clr in the cycle after an issue drops the read in flight
        p0 = n_pop;
        chk("pre_clr_wait_nonzero", K'(wait_cycles != 16'd0), K'(1));
        fork
            send(13'd40, 13'd41, 1'b0, 13'd600, 8'h66);
            begin
                wait_accept();
                @(negedge clk);
                chk("clr_issue", K'(rd_req_0), K'(1));
                @(posedge clk); #1;
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                sb.delete();
                @(negedge clk);
                chk("clr_out_valid", K'(out_valid), K'(0));
                chk("clr_wait", K'(wait_cycles), K'(0));
                chk("clr_idle", K'({in_ready, rd_req_0, rd_addr_0}), K'({1'b1, 1'b0, 13'd0}));
            end
        join
        repeat (5) @(negedge clk);
        chk("clr_no_output", K'(n_pop - p0), K'(0));
        @(posedge clk); #1;

        // randomized traffic
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(13'($urandom_range(0, 63)), 13'($urandom_range(0, 63)),
                         ($urandom_range(0, 7) == 0), 13'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    blk0 = ($urandom_range(0, 3) == 0);
                    blk1 = ($urandom_range(0, 3) == 0);
                    stall_rd = ($urandom_range(0, 4) == 0);
                    out_ready = ($urandom_range(0, 9) < 7);
                    @(posedge clk); #1;
                end
            end
        join
        blk0 = 1'b0; blk1 = 1'b0; stall_rd = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
